// File: rtl/sd_crc_framer_if.sv
// Bundle of the framer's write-buffer, CRC-engine and SPI-byte handshakes.
// master: environment side (write buffer, CRC engine, SPI shifter).
// slave : the framer itself.
interface sd_crc_framer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              crc_start;
    logic [DATA_W-1:0] crc_data;
    logic [16:0]       crc_in;
    logic              crc_done;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_byte;
    logic              frame_done;
    logic              crc_err;

    modport master (
        output in_valid, in_data, crc_in, crc_done, tx_ready,
        input  in_ready, crc_start, crc_data, tx_valid, tx_byte, frame_done, crc_err
    );

    modport slave (
        input  in_valid, in_data, crc_in, crc_done, tx_ready,
        output in_ready, crc_start, crc_data, tx_valid, tx_byte, frame_done, crc_err
    );
endinterface

// File: rtl/sd_crc_framer.sv
// sd_crc_framer: frames one DATA_W-bit word as [start token] data bytes
// (MSB byte first) and CRC-16 (high byte first) for the SPI SD write path.
// The CRC is obtained from an external engine via crc_start/crc_done.
// Optional feature macro: FRAMER_TOKEN_EN -- when defined, the START_TOKEN
// byte is sent ahead of the data bytes; when undefined the TOKEN state and
// the START_TOKEN parameter are absent.
module sd_crc_framer #(
    parameter int DATA_W      = 32,
    parameter int CRC_TIMEOUT = 255
`ifdef FRAMER_TOKEN_EN
    ,
    parameter logic [7:0] START_TOKEN = 8'hFE
`endif
) (
    input  logic           clk,
    input  logic           rst,
    sd_crc_framer_if.slave bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TCW    = $clog2(CRC_TIMEOUT + 1);

`ifdef FRAMER_TOKEN_EN
    typedef enum logic [2:0] {IDLE, CRC_REQ, CRC_WAIT, DATA, CRC_HI, CRC_LO, TOKEN} state_t;
`else
    typedef enum logic [2:0] {IDLE, CRC_REQ, CRC_WAIT, DATA, CRC_HI, CRC_LO} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       crc_q, crc_d;
    logic [TCW-1:0]    wcnt_q, wcnt_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [DATA_W-1:0] data_sh;

    // Current data byte always sits in the top 8 bits of the shifted copy;
    // data_q itself stays untouched so crc_data remains stable.
    assign data_sh      = data_q << {bcnt_q, 3'b000};
    assign bus.crc_data = data_q;

    // State, latched word/CRC and counters; reset abandons any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            crc_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state and outputs; tx_valid depends on state only, never on tx_ready.
    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        crc_d          = crc_q;
        wcnt_d         = wcnt_q;
        bcnt_d         = bcnt_q;
        bus.in_ready   = 1'b0;
        bus.crc_start  = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.tx_byte    = 8'h00;
        bus.frame_done = 1'b0;
        bus.crc_err    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    state_d = CRC_REQ;
                end
            end
            CRC_REQ: begin
                bus.crc_start = 1'b1;
                wcnt_d        = '0;
                state_d       = CRC_WAIT;
            end
            CRC_WAIT: begin
                // crc_done takes priority over a timeout in the same cycle
                if (bus.crc_done) begin
                    crc_d  = bus.crc_in[15:0];
                    bcnt_d = '0;
`ifdef FRAMER_TOKEN_EN
                    state_d = TOKEN;
`else
                    state_d = DATA;
`endif
                end else if (wcnt_q == TCW'(CRC_TIMEOUT)) begin
                    bus.crc_err = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wcnt_d = wcnt_q + TCW'(1);
                end
            end
`ifdef FRAMER_TOKEN_EN
            TOKEN: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = START_TOKEN;
                if (bus.tx_ready) state_d = DATA;
            end
`endif
            DATA: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = data_sh[DATA_W-1 -: 8];
                if (bus.tx_ready) begin
                    if (bcnt_q == BCW'(NBYTES - 1)) state_d = CRC_HI;
                    else                            bcnt_d  = bcnt_q + BCW'(1);
                end
            end
            CRC_HI: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = crc_q[15:8];
                if (bus.tx_ready) state_d = CRC_LO;
            end
            CRC_LO: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = crc_q[7:0];
                if (bus.tx_ready) begin
                    bus.frame_done = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
